// File: rtl/fib_pkg.sv
// Shared types and defaults for the Fibonacci stream checker.
package fib_pkg;

  typedef enum logic [1:0] {
    SEED0,
    SEED1,
    LOCKED
  } fib_chk_state_t;

  localparam int FIB_W_DEFAULT = 16;

endpackage

// File: rtl/fibonacci_checker_if.sv
// Beat bus from a Fibonacci generator into the checker: one or two terms per beat.
interface fibonacci_checker_if
  import fib_pkg::*;
#(
  parameter int W = FIB_W_DEFAULT
);

  logic         in_valid;
  logic         in_pair;
  logic [W-1:0] num;
  logic [W-1:0] num2;

  modport master (output in_valid, output in_pair, output num, output num2);
  modport slave  (input  in_valid, input  in_pair, input  num, input  num2);

endinterface

// File: rtl/fibonacci_checker_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (inc && (count_reg != '1)) begin
      count_reg <= count_reg + WIDTH'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/fibonacci_checker.sv
// Receive-side Fibonacci checker: seeds from the first two terms, then checks each term.
module fibonacci_checker
  import fib_pkg::*;
#(
  parameter int W     = FIB_W_DEFAULT,
  parameter int ERR_W = 8,
  parameter int CNT_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                restart,
  fibonacci_checker_if.slave  s,
  output logic                locked,
  output logic                err,
  output logic [ERR_W-1:0]    err_count,
  output logic [CNT_W-1:0]    term_count,
  output logic [W-1:0]        expected
);

  typedef struct packed {
    fib_chk_state_t state;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           pass;
    logic           mismatch;
  } step_t;

  // One word through the checker; a pair is two chained calls. A mismatching
  // word re-seeds as a, so a following num2 naturally becomes b.
  function automatic step_t fib_step(input fib_chk_state_t st,
                                     input logic [W-1:0] a,
                                     input logic [W-1:0] b,
                                     input logic [W-1:0] w);
    step_t        r;
    logic [W-1:0] sum;
    r.state    = st;
    r.a        = a;
    r.b        = b;
    r.pass     = 1'b0;
    r.mismatch = 1'b0;
    sum        = a + b;
    case (st)
      SEED0: begin
        r.a     = w;
        r.state = SEED1;
      end
      SEED1: begin
        r.b     = w;
        r.state = LOCKED;
      end
      default: begin
        if (w == sum) begin
          r.a    = b;
          r.b    = w;
          r.pass = 1'b1;
        end else begin
          r.a        = w;
          r.b        = '0;
          r.state    = SEED1;
          r.mismatch = 1'b1;
        end
      end
    endcase
    return r;
  endfunction

  fib_chk_state_t   state_reg, state_next;
  logic [W-1:0]     a_reg, a_next;
  logic [W-1:0]     b_reg, b_next;
  logic [W-1:0]     expected_reg, expected_next;
  logic             err_reg, err_next;
  logic [CNT_W-1:0] term_count_reg;
  logic [1:0]       pass_cnt;
  logic             err_inc;
  step_t            s1, s2;

  always_comb begin
    state_next    = state_reg;
    a_next        = a_reg;
    b_next        = b_reg;
    err_next      = 1'b0;
    err_inc       = 1'b0;
    pass_cnt      = 2'd0;
    s1            = fib_step(state_reg, a_reg, b_reg, s.num);
    s2            = fib_step(s1.state, s1.a, s1.b, s.num2);
    if (restart) begin
      state_next = SEED0;
      a_next     = '0;
      b_next     = '0;
    end else if (s.in_valid) begin
      if (s.in_pair) begin
        state_next = s2.state;
        a_next     = s2.a;
        b_next     = s2.b;
        pass_cnt   = {1'b0, s1.pass} + {1'b0, s2.pass};
        err_inc    = s1.mismatch | s2.mismatch;
      end else begin
        state_next = s1.state;
        a_next     = s1.a;
        b_next     = s1.b;
        pass_cnt   = {1'b0, s1.pass};
        err_inc    = s1.mismatch;
      end
      err_next = err_inc;
    end
    expected_next = (state_next == LOCKED) ? W'(a_next + b_next) : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= SEED0;
      a_reg          <= '0;
      b_reg          <= '0;
      expected_reg   <= '0;
      err_reg        <= 1'b0;
      term_count_reg <= '0;
    end else begin
      state_reg      <= state_next;
      a_reg          <= a_next;
      b_reg          <= b_next;
      expected_reg   <= expected_next;
      err_reg        <= err_next;
      term_count_reg <= term_count_reg + CNT_W'(pass_cnt);
    end
  end

  sat_counter #(
    .WIDTH (ERR_W)
  ) u_err_count (
    .clk   (clk),
    .rst   (rst),
    .inc   (err_inc),
    .count (err_count)
  );

  assign locked     = (state_reg == LOCKED);
  assign err        = err_reg;
  assign term_count = term_count_reg;
  assign expected   = expected_reg;

endmodule

// File: tb/tb_fibonacci_checker.sv
// Scoreboard bench for fibonacci_checker (W=16, ERR_W=2 to reach saturation quickly).
module tb_fibonacci_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        restart = 1'b0;
  logic        locked, err;
  logic [1:0]  err_count;
  logic [31:0] term_count;
  logic [15:0] expected;

  int checks   = 0;
  int failures = 0;
  int beat_no  = 0;
  int err_high = 0;

  typedef struct {
    logic        locked;
    logic        err;
    logic [1:0]  ec;
    logic [31:0] tc;
    logic [15:0] exp_v;
  } exp_t;
  exp_t sb_q[$];

  // Reference model state
  int          m_state = 0;
  logic [15:0] m_a = '0, m_b = '0;
  logic [1:0]  m_ec = '0;
  logic [31:0] m_tc = '0;

  fibonacci_checker_if #(.W(16)) bus ();

  fibonacci_checker #(
    .W     (16),
    .ERR_W (2),
    .CNT_W (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .restart    (restart),
    .s          (bus.slave),
    .locked     (locked),
    .err        (err),
    .err_count  (err_count),
    .term_count (term_count),
    .expected   (expected)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] req);
    checks++;
    if (obs !== req) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", tag, obs, req);
    end
  endtask

  task automatic model_word(input logic [15:0] w, output bit mism);
    logic [15:0] sum;
    mism = 1'b0;
    sum  = m_a + m_b;
    if (m_state == 0) begin
      m_a = w; m_state = 1;
    end else if (m_state == 1) begin
      m_b = w; m_state = 2;
    end else if (w == sum) begin
      m_a = m_b; m_b = w; m_tc++;
    end else begin
      m_a = w; m_b = '0; m_state = 1; mism = 1'b1;
    end
  endtask

  task automatic beat(input bit v, input bit p, input logic [15:0] n, input logic [15:0] n2,
                      input bit rs);
    exp_t        e;
    bit          mm, x;
    logic [15:0] sum;
    @(negedge clk);
    bus.in_valid = v; bus.in_pair = p; bus.num = n; bus.num2 = n2; restart = rs;
    mm = 1'b0;
    if (rs) begin
      m_state = 0; m_a = '0; m_b = '0;
    end else if (v) begin
      model_word(n, x); mm = x;
      if (p) begin
        model_word(n2, x);
        mm = mm | x;
      end
      if (mm && m_ec != 2'd3) m_ec++;
    end
    sum     = m_a + m_b;
    e.locked = (m_state == 2);
    e.err    = mm;
    e.ec     = m_ec;
    e.tc     = m_tc;
    e.exp_v  = (m_state == 2) ? sum : 16'd0;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    beat_no++;
    if (err) err_high++;
    $display("beat %0d v=%0d p=%0d rs=%0d num=%0d num2=%0d -> locked=%0d err=%0d ec=%0d tc=%0d exp=%0d",
             beat_no, v, p, rs, n, n2, locked, err, err_count, term_count, expected);
    check_val("locked", locked, e.locked);
    check_val("err", err, e.err);
    check_val("err_count", err_count, e.ec);
    check_val("term_count", term_count, e.tc);
    check_val("expected", expected, e.exp_v);
  endtask

  task automatic single(input logic [15:0] n);
    beat(1'b1, 1'b0, n, 16'd0, 1'b0);
  endtask

  task automatic pair(input logic [15:0] n, input logic [15:0] n2);
    beat(1'b1, 1'b1, n, n2, 1'b0);
  endtask

  // Asserts rst between clock edges and checks outputs clear without an edge.
  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    bus.in_valid = 1'b0; restart = 1'b0;
    #1;
    check_val("rst_locked", locked, 0);
    check_val("rst_err", err, 0);
    check_val("rst_err_count", err_count, 0);
    check_val("rst_term_count", term_count, 0);
    check_val("rst_expected", expected, 0);
    m_state = 0; m_a = '0; m_b = '0; m_ec = '0; m_tc = '0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [15:0] seq1 [6] = '{16'd1, 16'd1, 16'd2, 16'd3, 16'd5, 16'd8};
    logic [15:0] seq3 [6] = '{16'd1, 16'd1, 16'd2, 16'd4, 16'd5, 16'd9};
    bus.in_valid = 1'b0; bus.in_pair = 1'b0; bus.num = '0; bus.num2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check_val("por_locked", locked, 0);
    check_val("por_term_count", term_count, 0);
    @(negedge clk);
    rst = 1'b1;

    // Singles 1,1,2,3,5,8
    foreach (seq1[i]) single(seq1[i]);
    check_val("t1_locked", locked, 1);
    check_val("t1_term_count", term_count, 4);
    check_val("t1_expected", expected, 13);
    beat(1'b0, 1'b0, 16'd0, 16'd0, 1'b0);

    // Pairs (1,1),(2,3),(5,8)
    do_reset();
    pair(16'd1, 16'd1);
    pair(16'd2, 16'd3);
    pair(16'd5, 16'd8);
    check_val("t2_term_count", term_count, 4);
    check_val("t2_expected", expected, 13);

    // Seed split across a single and a pair, then a pair failing on num2
    do_reset();
    single(16'd1);
    pair(16'd1, 16'd2);
    pair(16'd3, 16'd7);
    check_val("t2b_locked", locked, 0);
    check_val("t2b_err_count", err_count, 1);

    // Singles 1,1,2,4,5,9 with resync on 4
    do_reset();
    for (int i = 0; i < 4; i++) single(seq3[i]);
    check_val("t3_err", err, 1);
    check_val("t3_locked", locked, 0);
    single(seq3[4]);
    check_val("t3_relock_expected", expected, 9);
    single(seq3[5]);
    check_val("t3_expected", expected, 14);
    check_val("t3_err_count", err_count, 1);
    check_val("t3_err_clear", err, 0);

    // Modulo-2^16 wrap
    do_reset();
    single(16'd28657);
    single(16'd46368);
    single(16'd9489);
    check_val("t4_term_count", term_count, 1);
    check_val("t4_expected", expected, 55857);
    check_val("t4_err", err, 0);

    // Mid-stream reset while locked, then 3,5,8
    single(16'd11);
    do_reset();
    single(16'd3);
    single(16'd5);
    single(16'd8);
    check_val("t5_locked", locked, 1);
    check_val("t5_term_count", term_count, 1);

    // Five consecutive bad beats saturating the 2-bit error counter
    do_reset();
    single(16'd1);
    single(16'd1);
    err_high = 0;
    for (int i = 0; i < 5; i++) pair(16'd100, 16'd100);
    check_val("t6_err_high_cycles", err_high, 5);
    check_val("t6_err_count", err_count, 3);
    beat(1'b0, 1'b0, 16'd0, 16'd0, 1'b0);
    check_val("t6_err_drop", err, 0);

    // restart together with a valid beat
    do_reset();
    single(16'd1);
    single(16'd1);
    single(16'd2);
    beat(1'b1, 1'b0, 16'd3, 16'd0, 1'b1);
    check_val("t7_locked", locked, 0);
    check_val("t7_expected", expected, 0);
    check_val("t7_term_count", term_count, 1);
    single(16'd21);
    single(16'd34);
    single(16'd55);
    check_val("t7_term_count_after", term_count, 2);

    check_val("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
